// File: rtl/etapa_fetch_if.sv
// Fetch-stage bus: debug-unit controls, hazard/redirect inputs, instruction memory and IF/ID payload.
// The slave modport is the fetch stage itself; the master modport is everything around it.
interface etapa_fetch_if #(
   parameter int NBITS = 32
);
   logic             i_Enable;
   logic             i_ModoPaso;
   logic             i_Step;
   logic             i_Stall;
   logic             i_Flush;
   logic             i_Branch;
   logic [NBITS-1:0] i_BranchAddr;
   logic             i_Jump;
   logic [NBITS-1:0] i_JumpAddr;
   logic [NBITS-1:0] i_Instruction;
   logic [NBITS-1:0] o_PC;
   logic [NBITS-1:0] o_Instruction_IFID;
   logic [NBITS-1:0] o_PC4_IFID;
   logic             o_Valid_IFID;
   logic             o_Halt;
   logic [31:0]      o_Fetched;

   modport master (
      output i_Enable, i_ModoPaso, i_Step, i_Stall, i_Flush,
             i_Branch, i_BranchAddr, i_Jump, i_JumpAddr, i_Instruction,
      input  o_PC, o_Instruction_IFID, o_PC4_IFID, o_Valid_IFID, o_Halt, o_Fetched
   );

   modport slave (
      input  i_Enable, i_ModoPaso, i_Step, i_Stall, i_Flush,
             i_Branch, i_BranchAddr, i_Jump, i_JumpAddr, i_Instruction,
      output o_PC, o_Instruction_IFID, o_PC4_IFID, o_Valid_IFID, o_Halt, o_Fetched
   );
endinterface

// File: rtl/etapa_fetch.sv
// Instruction fetch stage: PC sequencing with run/step/halt control, stall, flush and redirect,
// feeding a registered-read instruction memory and presenting the IF/ID payload.
module etapa_fetch #(
   parameter int               NBITS     = 32,
   parameter logic [NBITS-1:0] RESET_PC  = '0,
   parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input logic          i_clk,
   input logic          i_reset,
   etapa_fetch_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

   localparam logic [NBITS-1:0] PC_INC = NBITS'(4);

   state_t           state;
   logic [NBITS-1:0] pc;
   logic [NBITS-1:0] pc_d;
   logic [NBITS-1:0] next_pc;
   logic             valid_d;
   logic             step_prev;
   logic             halt;
   logic [31:0]      count;

   logic             step_rise;
   logic             halt_det;
   logic             redirect;
   logic             adv;
   logic             valid_out;

   always_comb begin
      step_rise = bus.i_Step && !step_prev;
      halt_det  = valid_d && (bus.i_Instruction == HALT_WORD) && !bus.i_Flush;
      redirect  = bus.i_Branch || bus.i_Jump;

      adv = 1'b0;
      case (state)
         RUN:     adv = !bus.i_Stall;
         STEP:    adv = step_rise && !bus.i_Stall;
         default: adv = 1'b0;
      endcase
      // A halt word in IF/ID must not let a younger address go out to memory.
      if (halt_det) adv = 1'b0;

      if (bus.i_Branch)    next_pc = bus.i_BranchAddr;
      else if (bus.i_Jump) next_pc = bus.i_JumpAddr;
      else                 next_pc = pc + PC_INC;

      valid_out = valid_d && !halt_det;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
         halt  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_Enable) state <= bus.i_ModoPaso ? STEP : RUN;
            end
            RUN, STEP: begin
               if (halt_det) begin
                  state <= HALTED;
                  halt  <= 1'b1;
               end
            end
            default: begin
               state <= HALTED;
               halt  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pc        <= RESET_PC;
         pc_d      <= RESET_PC;
         valid_d   <= 1'b0;
         step_prev <= 1'b0;
         count     <= '0;
      end else begin
         step_prev <= bus.i_Step;
         if (adv) begin
            pc   <= next_pc;
            pc_d <= pc;
         end
         // Flush beats stall; a redirect squashes the word fetched in the same cycle.
         if (bus.i_Flush)      valid_d <= 1'b0;
         else if (bus.i_Stall) valid_d <= valid_d;
         else if (adv)         valid_d <= !redirect;
         else                  valid_d <= 1'b0;
         if (adv && (count != 32'hFFFF_FFFF)) count <= count + 32'd1;
      end
   end

   // Held cycles re-present pc_d so the registered memory keeps returning the in-flight word.
   assign bus.o_PC               = adv ? pc : pc_d;
   assign bus.o_Instruction_IFID = valid_out ? bus.i_Instruction : '0;
   assign bus.o_PC4_IFID         = pc_d + PC_INC;
   assign bus.o_Valid_IFID       = valid_out;
   assign bus.o_Halt             = halt;
   assign bus.o_Fetched          = count;

endmodule

// File: tb/tb_etapa_fetch.sv
// Randomized bench for etapa_fetch: a fetch-level reference model predicts each IF/ID word,
// and a negedge monitor checks the DUT payload and fetch count against it.
module tb_etapa_fetch;
   localparam int          NBITS  = 32;
   localparam logic [31:0] RST_PC = 32'd4;
   localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] ins;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] halt_addr = 32'hFFFF_FFFF;

   etapa_fetch_if #(.NBITS(NBITS)) bus ();

   etapa_fetch #(.NBITS(NBITS), .RESET_PC(RST_PC), .HALT_WORD(HALT)) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == halt_addr) return HALT;
      return {a[15:0] ^ 16'h1234, ~a[15:0]};
   endfunction

   always @(posedge clk) bus.i_Instruction <= mem_word(bus.o_PC);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: which addresses get fetched and which of them reach IF/ID.
   item_t       sb[$];
   item_t       last;
   item_t       it;
   int          m_mode;       // 0 idle, 1 run, 2 step, 3 halted
   logic [31:0] m_pc, m_fly, m_count;
   logic        m_live, m_sprev, m_prev_stall;
   logic        go, halting, nl;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_pc = RST_PC; m_fly = RST_PC; m_count = 0;
         m_live = 0; m_sprev = 0; m_prev_stall = 0;
         sb.delete();
      end else begin
         halting = m_live && (mem_word(m_fly) == HALT) && !bus.i_Flush;
         go = 1'b0;
         if (m_mode == 1) go = !bus.i_Stall;
         if (m_mode == 2) go = bus.i_Step && !m_sprev && !bus.i_Stall;
         if (halting) go = 1'b0;
         if (bus.i_Flush)      nl = 1'b0;
         else if (bus.i_Stall) nl = m_live;
         else                  nl = go && !(bus.i_Branch || bus.i_Jump);
         if (go) begin
            m_fly = m_pc;
            m_pc  = bus.i_Branch ? bus.i_BranchAddr : bus.i_Jump ? bus.i_JumpAddr : m_pc + 32'd4;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (nl && mem_word(m_fly) != HALT) begin
               it.pc4 = m_fly + 32'd4;
               it.ins = mem_word(m_fly);
               sb.push_back(it);
            end
         end
         m_live = nl;
         if (halting) m_mode = 3;
         else if (m_mode == 0 && bus.i_Enable) m_mode = bus.i_ModoPaso ? 2 : 1;
         m_sprev      = bus.i_Step;
         m_prev_stall = bus.i_Stall;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("fetched", bus.o_Fetched, m_count);
         if (bus.o_Valid_IFID) begin
            if (!m_prev_stall) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL sb_underflow: valid word pc4=%h with nothing expected", bus.o_PC4_IFID);
               end else last = sb.pop_front();
            end
            check("ifid_pc4", bus.o_PC4_IFID, last.pc4);
            check("ifid_ins", bus.o_Instruction_IFID, last.ins);
         end else begin
            check("nop_ins", bus.o_Instruction_IFID, 32'd0);
         end
         check("sb_pending", 32'(sb.size()), 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.i_Stall = 0; bus.i_Flush = 0; bus.i_Step = 0;
      bus.i_Branch = 0; bus.i_BranchAddr = 0; bus.i_Jump = 0; bus.i_JumpAddr = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_Enable = 0; bus.i_ModoPaso = 0;
      quiet();
      #1;
      check("rst_pc", bus.o_PC, RST_PC);
      check("rst_valid", 32'(bus.o_Valid_IFID), 32'd0);
      check("rst_ins", bus.o_Instruction_IFID, 32'd0);
      check("rst_halt", 32'(bus.o_Halt), 32'd0);
      check("rst_fetched", bus.o_Fetched, 32'd0);
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rnd_target();
      return 32'($urandom_range(0, 63)) << 2;
   endfunction

   initial begin
      bus.i_Enable = 0; bus.i_ModoPaso = 0;
      quiet();
      tick();
      do_reset();

      // Continuous run from RESET_PC.
      bus.i_Enable = 1;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("run_pc", bus.o_PC, RST_PC + 32'(4 * i));
         tick();
      end
      check("run_pc16", bus.o_PC, 32'd16);
      bus.i_Stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_pc", bus.o_PC, 32'd12);
         tick();
      end
      bus.i_Stall = 0;
      tick();

      bus.i_Branch = 1; bus.i_BranchAddr = 32'd52;
      tick();
      quiet();
      check("branch_pc", bus.o_PC, 32'd52);
      tick(); tick();
      bus.i_Branch = 1; bus.i_BranchAddr = 32'd52; bus.i_Jump = 1; bus.i_JumpAddr = 32'd20;
      tick();
      quiet();
      check("br_jmp_pc", bus.o_PC, 32'd52);
      tick();
      bus.i_Branch = 1; bus.i_BranchAddr = 32'hFFFF_FFFC;
      tick();
      quiet();
      check("wrap_top", bus.o_PC, 32'hFFFF_FFFC);
      tick();
      check("wrap_zero", bus.o_PC, 32'd0);

      for (int i = 0; i < 300; i++) begin
         bus.i_Stall      = ($urandom_range(0, 3) == 0);
         bus.i_Flush      = ($urandom_range(0, 9) == 0);
         bus.i_Branch     = ($urandom_range(0, 9) == 0);
         bus.i_BranchAddr = rnd_target();
         bus.i_Jump       = ($urandom_range(0, 9) == 0);
         bus.i_JumpAddr   = rnd_target();
         tick();
      end
      quiet();
      tick();

      // Single-step mode, reset taken mid-run.
      do_reset();
      bus.i_Enable = 1; bus.i_ModoPaso = 1;
      tick();
      bus.i_Step = 1;
      repeat (5) tick();
      bus.i_Step = 0;
      tick(); tick();
      check("step_hold", bus.o_Fetched, 32'd1);
      repeat (2) begin
         bus.i_Step = 1; tick();
         bus.i_Step = 0; tick();
      end
      check("step_pulses", bus.o_Fetched, 32'd3);

      for (int i = 0; i < 200; i++) begin
         bus.i_Step       = $urandom_range(0, 1) == 1;
         bus.i_Stall      = ($urandom_range(0, 4) == 0);
         bus.i_Flush      = ($urandom_range(0, 9) == 0);
         bus.i_Branch     = ($urandom_range(0, 7) == 0);
         bus.i_BranchAddr = rnd_target();
         bus.i_Jump       = ($urandom_range(0, 7) == 0);
         bus.i_JumpAddr   = rnd_target();
         tick();
      end
      quiet();
      tick();

      // Halt word at address 16.
      do_reset();
      halt_addr = 32'd16;
      bus.i_Enable = 1; bus.i_ModoPaso = 0;
      begin
         int n;
         n = 0;
         while (!bus.o_Halt && n < 20) begin
            tick();
            n++;
         end
         check("halt_reached", 32'(bus.o_Halt), 32'd1);
      end
      for (int i = 0; i < 3; i++) begin
         check("halt_pc", bus.o_PC, 32'd16);
         check("halt_flag", 32'(bus.o_Halt), 32'd1);
         tick();
      end
      check("halt_fetched", bus.o_Fetched, 32'd4);

      do_reset();
      halt_addr = 32'hFFFF_FFFF;
      repeat (3) tick();
      check("idle_pc", bus.o_PC, RST_PC);
      check("idle_halt", 32'(bus.o_Halt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/etapa_fetch.md
ETAPA_FETCH -- requirements
Module: etapa_fetch

Interface
REQ-001 SHALL have parameter NBITS, default 32: PC and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that stops fetch.
REQ-004 i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_Enable  in  1  start request from debug unit, level.
REQ-007 i_ModoPaso  in  1  1 = single-step mode, 0 = continuous; sampled only in IDLE.
REQ-008 i_Step  in  1  step request, level; rising edge is detected internally.
REQ-009 i_Stall  in  1  hazard stall: hold PC and IF/ID outputs.
REQ-010 i_Flush  in  1  squash the instruction currently in fetch.
REQ-011 i_Branch / i_BranchAddr  in  1 / NBITS  branch taken and its target.
REQ-012 i_Jump / i_JumpAddr  in  1 / NBITS  jump taken and its target.
REQ-013 i_Instruction  in  NBITS  instruction-memory data, registered one cycle after address.
REQ-014 o_PC  out  NBITS  address to instruction memory.
REQ-015 o_Instruction_IFID / o_PC4_IFID / o_Valid_IFID  out  NBITS / NBITS / 1  IF/ID payload.
REQ-016 o_Halt / o_Fetched  out  1 / 32  halted flag and fetched-instruction count.

Function
REQ-017 SHALL keep registers pc, pc_d (address in flight), valid_d, state, step_prev, count.
REQ-018 States: IDLE, RUN, STEP, HALTED; IDLE->RUN on i_Enable && !i_ModoPaso; IDLE->STEP on i_Enable && i_ModoPaso; RUN/STEP->HALTED on halt detect; HALTED exits only by reset.
REQ-019 adv SHALL be: RUN: !i_Stall; STEP: (i_Step && !step_prev) && !i_Stall; IDLE/HALTED: 0.
REQ-020 next_pc SHALL be: i_Branch ? i_BranchAddr : i_Jump ? i_JumpAddr : pc+4 (mod 2^NBITS, wrap to 0 silently).
REQ-021 On adv: pc <= next_pc, pc_d <= pc; otherwise pc, pc_d hold.
REQ-022 o_PC SHALL be combinational: adv ? pc : pc_d, so a held cycle re-reads the in-flight word.
REQ-023 valid_d: i_Flush -> 0; else i_Stall -> hold; else adv -> !(i_Branch || i_Jump); else 0.
REQ-024 Branch/jump in an adv cycle squash the fetched word (one bubble); no squash applied when adv = 0 but target still SHALL be captured only when adv = 1.
REQ-025 o_Instruction_IFID = valid_out ? i_Instruction : 0 (NOP); o_PC4_IFID = pc_d + 4; o_Valid_IFID = valid_out.
REQ-026 Halt detect: valid_d && i_Instruction == HALT_WORD && !i_Flush; same cycle valid_out = 0, adv forced 0; next edge state <= HALTED.
REQ-027 o_Halt SHALL be 1 exactly when state == HALTED.
REQ-028 count SHALL increment by 1 on every adv edge, saturating at 2^32-1.
REQ-029 Simultaneous i_Stall and i_Flush: flush wins for valid_d, PC still held.

Reset
REQ-030 On i_reset (async): pc = RESET_PC, pc_d = RESET_PC, valid_d = 0, state = IDLE, step_prev = 0, count = 0.
REQ-031 During/after reset: o_PC = RESET_PC, o_Valid_IFID = 0, o_Instruction_IFID = 0, o_Halt = 0, o_Fetched = 0.
REQ-032 Reset asserted mid-RUN or in HALTED SHALL return to IDLE within the same cycle, no further fetch until i_Enable.

Verification
REQ-033 RESET_PC=4, i_Enable=1, ModoPaso=0: o_PC 4,8,12,...; o_PC4_IFID = 8,12,... one cycle behind; o_Valid_IFID=1 from 2nd cycle.
REQ-034 Stall held 3 cycles at o_PC=16: o_PC stays 12 (pc_d) each held cycle, IF/ID payload unchanged, count frozen.
REQ-035 i_Branch=1, i_BranchAddr=52 in RUN: next o_PC=52, one cycle o_Valid_IFID=0, then instruction at 52 with o_PC4_IFID=56.
REQ-036 Branch and jump same cycle (targets 52, 20): PC=52.
REQ-037 Step mode: i_Step held high 5 cycles -> exactly one advance; three pulses -> o_Fetched=3.
REQ-038 HALT_WORD arrives at i_Instruction: o_Valid_IFID=0 that cycle, o_Halt=1 next cycle, o_PC frozen; i_reset -> IDLE, o_PC=RESET_PC.
